sram_bus_arbiter: RTL and testbench

Shares one SRAM-like memory port between the IF-stage instruction requester and the EX/MEM-stage data requester. Uses req/addr_ok/data_ok split-transaction handshakes on every side. Grants one address phase at a time and holds the grant until that phase is accepted. Records the owner of each in-flight transaction in an in-order ID FIFO and routes each `data_ok`/`rdata` back to that owner. Sits between the pipeline stages and the AXI bridge / memory model.

---
 rtl/sram_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one SRAM-like memory port between the instruction fetch requester
//   and the data (load/store) requester. One address phase is granted at a
//   time and the grant is held until the bus accepts it. The owner of every
//   accepted transaction is queued in an in-order ID FIFO so each response
//   (data_ok/rdata) is routed back to the requester that issued it.
//
// Parameters
//   OUTSTANDING   max in-flight accepted transactions (power of 2, >= 2)
//   STARVE_LIMIT  consecutive data accepts, while inst_req waits, before the
//                 instruction side is forced through once
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   inst_req/inst_addr                 fetch request (word reads only)
//   inst_addr_ok/inst_data_ok/rdata    fetch handshakes and data
//   data_req/wr/size/wstrb/addr/wdata  load/store request
//   data_addr_ok/data_data_ok/rdata    data handshakes and load data
//   bus_*                              shared memory-side port
//   err_unexp                          sticky: response seen with FIFO empty
module sram_bus_arbiter #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        err_unexp
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OUTSTANDING-1:0] id_mem;   // 0 = instruction, 1 = data
    logic [STV_W-1:0]   starve_cnt;
    logic               err_q;

    logic               full;
    logic               empty;
    logic               starved;
    logic               grant_valid;
    logic               owner_data;
    logic               accept;
    logic               resp_valid;
    logic               head_data;

    // Full/empty use the registered count only, so a response arriving this
    // cycle never re-opens the grant path combinationally.
    assign full    = (count == CNT_W'(OUTSTANDING));
    assign empty   = (count == '0);
    assign starved = (starve_cnt == STV_W'(STARVE_LIMIT));

    // Arbitration and hold FSM
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        owner_data  = 1'b0;
        case (state)
            IDLE: begin
                if (!full) begin
                    if (starved && inst_req) begin
                        grant_valid = 1'b1;
                        owner_data  = 1'b0;
                    end else if (data_req) begin
                        grant_valid = 1'b1;
                        owner_data  = 1'b1;
                    end else if (inst_req) begin
                        grant_valid = 1'b1;
                        owner_data  = 1'b0;
                    end
                end
                if (grant_valid && !bus_addr_ok) begin
                    state_next = owner_data ? HOLD_D : HOLD_I;
                end
            end
            HOLD_I: begin
                // Owner keeps req/payload stable; no re-arbitration here.
                grant_valid = 1'b1;
                owner_data  = 1'b0;
                if (bus_addr_ok) state_next = IDLE;
            end
            HOLD_D: begin
                grant_valid = 1'b1;
                owner_data  = 1'b1;
                if (bus_addr_ok) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant mux: the owner drives the bus in the same cycle
    assign bus_req   = grant_valid && !reset;
    assign bus_wr    = owner_data ? data_wr    : 1'b0;
    assign bus_size  = owner_data ? data_size  : 2'd2;
    assign bus_wstrb = owner_data ? data_wstrb : 4'b0000;
    assign bus_addr  = owner_data ? data_addr  : inst_addr;
    assign bus_wdata = owner_data ? data_wdata : 32'h0;

    assign accept       = bus_req && bus_addr_ok;
    assign inst_addr_ok = accept && !owner_data;
    assign data_addr_ok = accept &&  owner_data;

    // Response routing from the FIFO head; a response with nothing in
    // flight is not forwarded to anyone and only flags the error.
    assign head_data    = id_mem[rd_ptr];
    assign resp_valid   = bus_data_ok && !empty && !reset;
    assign inst_data_ok = resp_valid && !head_data;
    assign data_data_ok = resp_valid &&  head_data;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign err_unexp    = err_q;

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;

            if (accept)     wr_ptr <= wr_ptr + PTR_W'(1);
            if (resp_valid) rd_ptr <= rd_ptr + PTR_W'(1);

            case ({accept, resp_valid})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (!inst_req || inst_addr_ok) begin
                starve_cnt <= '0;
            end else if (data_addr_ok && !starved) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end

            if (bus_data_ok && empty) err_q <= 1'b1;
        end
    end

    // ID storage: contents are only meaningful between push and pop, so no reset
    always_ff @(posedge clk) begin
        if (accept) id_mem[wr_ptr] <= owner_data;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h0000_1000;
    localparam logic [31:0] SA = 32'h0000_2003;
    localparam logic [31:0] WD = 32'h1100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        err_unexp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .err_unexp(err_unexp)
    );

    typedef struct {
        logic        rst, ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [1:0]  dsz;
        logic [3:0]  dst;
        logic [31:0] da;
        logic        aok, dok;
        logic [31:0] rd;
        logic        breq, bwr;
        logic [1:0]  bsz;
        logic [3:0]  bst;
        logic [31:0] ba;
        logic        iaok, daok, idok, ddok, err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, ir, input logic [31:0] ia,
                       input logic dr, dw, input logic [1:0] dsz, input logic [3:0] dst,
                       input logic [31:0] da, input logic aok, dok, input logic [31:0] rd,
                       input logic breq, bwr, input logic [1:0] bsz, input logic [3:0] bst,
                       input logic [31:0] ba, input logic iaok, daok, idok, ddok, err);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dsz = dsz;
        v.dst = dst; v.da = da; v.aok = aok; v.dok = dok; v.rd = rd;
        v.breq = breq; v.bwr = bwr; v.bsz = bsz; v.bst = bst; v.ba = ba;
        v.iaok = iaok; v.daok = daok; v.idok = idok; v.ddok = ddok; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        reset = 1'b0; inst_req = 1'b0; inst_addr = IA;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'b0;
        data_addr = DA; data_wdata = WD;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        //   rst ir ia      dr dw sz st     da  aok dok rd              breq bwr sz st     ba      iaok daok idok ddok err
        add(1, 1, IA,     1, 0, 2, 4'h0, DA, 1, 1, 32'h0,          0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 0);
        // simultaneous requests: data first, instruction next, in-order responses
        add(0, 1, IA,     1, 0, 2, 4'h0, DA, 1, 0, 32'h0,          1, 0, 2, 4'h0, DA,     0, 1, 0, 0, 0);
        add(0, 1, IA,     0, 0, 2, 4'h0, DA, 1, 0, 32'h0,          1, 0, 2, 4'h0, IA,     1, 0, 0, 0, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 1, 1, 32'hAAAA0001,   0, 0, 2, 4'h0, IA,     0, 0, 0, 1, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 1, 1, 32'hBBBB0002,   0, 0, 2, 4'h0, IA,     0, 0, 1, 0, 0);
        // three fetches, FIFO depth 2: third waits, pop does not bypass
        add(0, 1, 32'h100, 0, 0, 2, 4'h0, DA, 1, 0, 32'h0,         1, 0, 2, 4'h0, 32'h100, 1, 0, 0, 0, 0);
        add(0, 1, 32'h104, 0, 0, 2, 4'h0, DA, 1, 0, 32'h0,         1, 0, 2, 4'h0, 32'h104, 1, 0, 0, 0, 0);
        add(0, 1, 32'h108, 0, 0, 2, 4'h0, DA, 1, 0, 32'h0,         0, 0, 2, 4'h0, 32'h108, 0, 0, 0, 0, 0);
        add(0, 1, 32'h108, 0, 0, 2, 4'h0, DA, 1, 1, 32'hC1,        0, 0, 2, 4'h0, 32'h108, 0, 0, 1, 0, 0);
        add(0, 1, 32'h108, 0, 0, 2, 4'h0, DA, 1, 0, 32'h0,         1, 0, 2, 4'h0, 32'h108, 1, 0, 0, 0, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 1, 32'hC2,         0, 0, 2, 4'h0, IA,     0, 0, 1, 0, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 1, 32'hC3,         0, 0, 2, 4'h0, IA,     0, 0, 1, 0, 0);
        // unexpected response with FIFO empty: sticky error until reset
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 1, 32'hDEAD,       0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 0, 32'h0,          0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 1);
        add(1, 1, IA,     1, 0, 2, 4'h0, DA, 1, 1, 32'h0,          0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 1);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 0, 32'h0,          0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 0);
        // reset with a transaction in flight discards its ID
        add(0, 1, IA,     0, 0, 2, 4'h0, DA, 1, 0, 32'h0,          1, 0, 2, 4'h0, IA,     1, 0, 0, 0, 0);
        add(1, 0, IA,     0, 0, 2, 4'h0, DA, 0, 0, 32'h0,          0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 1, 32'h77,         0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 0, 32'h0,          0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 1);
        add(1, 0, IA,     0, 0, 2, 4'h0, DA, 0, 0, 32'h0,          0, 0, 2, 4'h0, IA,     0, 0, 0, 0, 1);
        // single fetch, addr_ok after two wait cycles
        add(0, 1, IA,     0, 0, 2, 4'h0, DA, 0, 0, 32'h0,          1, 0, 2, 4'h0, IA,     0, 0, 0, 0, 0);
        add(0, 1, IA,     0, 0, 2, 4'h0, DA, 0, 0, 32'h0,          1, 0, 2, 4'h0, IA,     0, 0, 0, 0, 0);
        add(0, 1, IA,     0, 0, 2, 4'h0, DA, 1, 0, 32'h0,          1, 0, 2, 4'h0, IA,     1, 0, 0, 0, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 1, 32'h02800C0C,   0, 0, 2, 4'h0, IA,     0, 0, 1, 0, 0);
        // byte store held in HOLD_D while inst_req rises
        add(0, 0, IA,     1, 1, 0, 4'h8, SA, 0, 0, 32'h0,          1, 1, 0, 4'h8, SA,     0, 0, 0, 0, 0);
        add(0, 1, IA,     1, 1, 0, 4'h8, SA, 0, 0, 32'h0,          1, 1, 0, 4'h8, SA,     0, 0, 0, 0, 0);
        add(0, 1, IA,     1, 1, 0, 4'h8, SA, 0, 0, 32'h0,          1, 1, 0, 4'h8, SA,     0, 0, 0, 0, 0);
        add(0, 1, IA,     1, 1, 0, 4'h8, SA, 1, 0, 32'h0,          1, 1, 0, 4'h8, SA,     0, 1, 0, 0, 0);
        add(0, 1, IA,     0, 0, 2, 4'h0, DA, 0, 1, 32'h0,          1, 0, 2, 4'h0, IA,     0, 0, 0, 1, 0);
        add(0, 1, IA,     0, 0, 2, 4'h0, DA, 1, 0, 32'h0,          1, 0, 2, 4'h0, IA,     1, 0, 0, 0, 0);
        add(0, 0, IA,     0, 0, 2, 4'h0, DA, 0, 1, 32'h55,         0, 0, 2, 4'h0, IA,     0, 0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            reset = tbl[i].rst; inst_req = tbl[i].ir; inst_addr = tbl[i].ia;
            data_req = tbl[i].dr; data_wr = tbl[i].dw; data_size = tbl[i].dsz;
            data_wstrb = tbl[i].dst; data_addr = tbl[i].da; data_wdata = WD;
            bus_addr_ok = tbl[i].aok; bus_data_ok = tbl[i].dok; bus_rdata = tbl[i].rd;
            #3;
            chk($sformatf("v%0d bus_req", i), 32'(bus_req), 32'(tbl[i].breq));
            chk($sformatf("v%0d inst_addr_ok", i), 32'(inst_addr_ok), 32'(tbl[i].iaok));
            chk($sformatf("v%0d data_addr_ok", i), 32'(data_addr_ok), 32'(tbl[i].daok));
            chk($sformatf("v%0d inst_data_ok", i), 32'(inst_data_ok), 32'(tbl[i].idok));
            chk($sformatf("v%0d data_data_ok", i), 32'(data_data_ok), 32'(tbl[i].ddok));
            chk($sformatf("v%0d err_unexp", i), 32'(err_unexp), 32'(tbl[i].err));
            chk($sformatf("v%0d inst_rdata", i), inst_rdata, tbl[i].rd);
            chk($sformatf("v%0d data_rdata", i), data_rdata, tbl[i].rd);
            if (tbl[i].breq) begin
                chk($sformatf("v%0d bus_wr", i), 32'(bus_wr), 32'(tbl[i].bwr));
                chk($sformatf("v%0d bus_size", i), 32'(bus_size), 32'(tbl[i].bsz));
                chk($sformatf("v%0d bus_wstrb", i), 32'(bus_wstrb), 32'(tbl[i].bst));
                chk($sformatf("v%0d bus_addr", i), bus_addr, tbl[i].ba);
                if (tbl[i].bwr) chk($sformatf("v%0d bus_wdata", i), bus_wdata, WD);
            end
        end

        // Starvation: data requests back to back with inst_req held high.
        // Memory answers each accept one cycle later.
        @(posedge clk); #1;
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            inst_req = 1'b1; inst_addr = IA;
            data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = DA;
            bus_addr_ok = 1'b1; bus_data_ok = (k > 0); bus_rdata = 32'(k);
            #3;
            chk($sformatf("starve%0d inst_addr_ok", k), 32'(inst_addr_ok), 32'(k == 4));
            chk($sformatf("starve%0d data_addr_ok", k), 32'(data_addr_ok), 32'(k != 4));
            chk($sformatf("starve%0d bus_addr", k), bus_addr, (k == 4) ? IA : DA);
            chk($sformatf("starve%0d inst_data_ok", k), 32'(inst_data_ok), 32'(k == 5));
            chk($sformatf("starve%0d data_data_ok", k), 32'(data_data_ok), 32'(k > 0 && k != 5));
            @(posedge clk); #1;
        end
        drive_idle();
        @(posedge clk); #1;
        chk("final err_unexp", 32'(err_unexp), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
